// File: rtl/dma_fifo_drain.sv
// Drain side of the 512-byte one-shot DMA FIFO: initialises the FIFO, then moves
// each byte into memory through a req/ack write port at an incrementing address.
module dma_fifo_drain #(
    parameter int ADDR_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_init,
    output logic                  fifo_rd_stb,
    input  logic                  fifo_empty,
    input  logic                  fifo_rdone,
    input  logic [7:0]            fifo_rd,
    output logic                  dma_req,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic [7:0]            dma_wd,
    input  logic                  dma_ack,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_WAIT  = 3'd2,
        S_FETCH = 3'd3,
        S_REQ   = 3'd4,
        S_STEP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t state;

    assign dbg_state = state;

    // Handshake: dma_req rises on entry to REQ and holds dma_addr/dma_wd stable until
    // the cycle dma_ack is seen; the write completes on that cycle, and dma_req drops
    // in STEP. An abort may withdraw dma_req before any ack arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            fifo_init   <= 1'b0;
            fifo_rd_stb <= 1'b0;
            dma_req     <= 1'b0;
            dma_addr    <= '0;
            dma_wd      <= '0;
        end else begin
            fifo_init   <= 1'b0;
            fifo_rd_stb <= 1'b0;
            done        <= 1'b0;
            // Abort beats everything else, including an ack landing in the same cycle.
            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                dma_req <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_INIT;
                            dma_addr  <= addr_in;
                            busy      <= 1'b1;
                            fifo_init <= 1'b1;
                        end
                    end
                    S_INIT: state <= S_WAIT;
                    S_WAIT: begin
                        if (fifo_rdone) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (!fifo_empty) begin
                            state <= S_FETCH;
                        end
                    end
                    // The RAM output register settles during FETCH; capture it at the end.
                    S_FETCH: begin
                        dma_wd  <= fifo_rd;
                        dma_req <= 1'b1;
                        state   <= S_REQ;
                    end
                    S_REQ: begin
                        if (dma_ack) begin
                            dma_req     <= 1'b0;
                            fifo_rd_stb <= 1'b1;
                            state       <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        dma_addr <= dma_addr + ADDR_ONE;
                        state    <= S_WAIT;
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        dma_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
